aes_key_sched_ctrl: RTL
=======================

# aes_key_sched_ctrl

Sequencing controller for AES-128 key expansion. It accepts a cipher key over a valid/ready handshake and drives one external single-round key-step datapath (`step_key_o`, `step_rcon_o` in; `step_key_i` back) once per cycle for NR rounds. It stores all NR+1 round keys in an internal register file and serves them to the cipher datapath through a combinational read port. The step datapath is purely combinational; this block owns the round counter, the Rcon sequence, the storage and the handshakes.

## Interface
- NR, default 10: number of expansion rounds; storage holds NR+1 keys. Only values up to 10 are supported, since the Rcon sequence is defined up to 0x36.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- key_i  in  128  cipher key; opaque to this block.
- key_valid_i  in  1  key load request.
- key_ready_o  out  1  load accepted when key_valid_i && key_ready_o at an edge.
- flush_i  in  1  synchronous abort/invalidate.
- step_key_o  out  128  current key presented to the step datapath.
- step_rcon_o  out  8  Rcon for the current step.
- step_key_i  in  128  next round key from the step datapath, valid in the same cycle.
- rk_idx_i  in  4  round-key read index.
- rk_o  out  128  round key at rk_idx_i; combinational.
- keys_valid_o  out  1  all NR+1 round keys are valid.
- busy_o  out  1  expansion in progress.

## Operation
- State registers:
  - FSM with states IDLE, EXPAND, DONE.
  - rnd, 4-bit round counter.
  - rcon, 8-bit.
  - cur, 128-bit; drives step_key_o.
  - kmem[0:NR], 128 bits each.
- step_rcon_o = rcon. step_key_o = cur.
- Reset values:
  - FSM = IDLE, rnd = 0, rcon = 8'h01, cur = 0, all kmem = 0.
  - keys_valid_o = 0, busy_o = 0.
  - key_ready_o = 1, since the output is decoded from the FSM.
- key_ready_o = 1 in IDLE and DONE, 0 in EXPAND. busy_o = 1 only in EXPAND.
- IDLE/DONE with an accepted load:
  - kmem[0] ← key_i, cur ← key_i.
  - rnd ← 1, rcon ← 8'h01.
  - keys_valid_o ← 0; FSM → EXPAND.
- EXPAND, each cycle:
  - kmem[rnd] ← step_key_i, cur ← step_key_i.
  - rcon ← xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - rnd ← rnd+1.
  - When rnd == NR: FSM → DONE, keys_valid_o ← 1.
- Resulting step_rcon_o sequence over the EXPAND cycles: 01 02 04 08 10 20 40 80 1b 36.
- key_valid_i is ignored in EXPAND; no queuing.
- flush_i, in any state: FSM → IDLE, keys_valid_o ← 0, rnd ← 0, rcon ← 8'h01. kmem is not cleared.
- flush_i takes priority over a simultaneous load; that load is not accepted.
- Read port:
  - rk_o = kmem[rk_idx_i] for rk_idx_i ≤ NR; 128'h0 for rk_idx_i > NR.
  - During EXPAND it returns partially updated contents. Consumers gate on keys_valid_o.
- Reset asserted mid-expansion returns every register to its reset value immediately (asynchronous).

## Timing
- Load accepted at edge E0. Round keys k1…kNR are written at edges E1…ENR.
- keys_valid_o rises at edge ENR, i.e. NR cycles after acceptance (10 for the default).
- busy_o is high for exactly NR cycles.
- Back-to-back: a load accepted at the same edge keys_valid_o rises is impossible, because ready is 0 in EXPAND. The earliest reload is the first cycle in DONE. Throughput is one key per NR+1 cycles.
- Reload in DONE: keys_valid_o falls at the accept edge.
- rk_o has zero-cycle latency from rk_idx_i.
- step_key_o and step_rcon_o are registered. The step-datapath path from cur to kmem is the critical path.

## Test plan
- Reset values: hold rst_ni = 0, then release.
  - Required: key_ready_o = 1, busy_o = 0, keys_valid_o = 0, step_rcon_o = 01, rk_o = 0 for all indices.
- FIPS-197 key, using the team step datapath:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: keys_valid_o exactly 10 cycles after accept.
  - Required: rk_o[idx 0] = the key; rk_o[idx 10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: step_rcon_o sequence 01,02,04,08,10,20,40,80,1b,36 on consecutive cycles.
- All-zero key:
  - Required: rk_o[idx 1] = 62636363626363636263636362636363; busy_o high exactly 10 cycles.
- Handshake:
  - Stimulus: key_valid_i held high during EXPAND with a different key.
  - Required: key_ready_o = 0 and the result is unchanged.
  - Stimulus: reload in DONE.
  - Required: keys_valid_o drops at the accept edge and rises again 10 cycles later with the new keys.
- Flush:
  - Stimulus: flush_i at rnd = 5.
  - Required: next cycle FSM is IDLE, keys_valid_o = 0, busy_o = 0, step_rcon_o = 01.
  - Stimulus: flush_i and key_valid_i in the same cycle.
  - Required: no acceptance; the block stays in IDLE.
- Boundaries:
  - Stimulus: rk_idx_i = 11…15.
  - Required: rk_o = 0.
  - Stimulus: rst_ni pulsed low mid-EXPAND, off-edge.
  - Required: outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: loads a cipher key, steps an external
// single-round key datapath NR times and serves the stored round keys.
module aes_key_sched_ctrl #(
   parameter int unsigned NR = 10
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [127:0] key_i,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic         flush_i,
   output logic [127:0] step_key_o,
   output logic [7:0]   step_rcon_o,
   input  logic [127:0] step_key_i,
   input  logic [3:0]   rk_idx_i,
   output logic [127:0] rk_o,
   output logic         keys_valid_o,
   output logic         busy_o
);

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned RCON_W = 8;
   localparam int unsigned IDX_W  = 4;
   localparam logic [IDX_W-1:0]  NR_L      = IDX_W'(NR);
   localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    rnd_q, rnd_d;
   logic [RCON_W-1:0]   rcon_q, rcon_d;
   logic [KEY_W-1:0]    cur_q, cur_d;
   logic                keys_valid_q, keys_valid_d;
   logic [KEY_W-1:0]    kmem_q [0:NR];
   logic [KEY_W-1:0]    kmem_d [0:NR];

   // GF(2^8) multiply-by-two used to advance Rcon
   function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         rnd_q        <= '0;
         rcon_q       <= RCON_INIT;
         cur_q        <= '0;
         keys_valid_q <= 1'b0;
         kmem_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         rnd_q        <= rnd_d;
         rcon_q       <= rcon_d;
         cur_q        <= cur_d;
         keys_valid_q <= keys_valid_d;
         kmem_q       <= kmem_d;
      end
   end

   // Next-state logic: flush overrides everything, including a same-cycle load
   always_comb begin
      state_d      = state_q;
      rnd_d        = rnd_q;
      rcon_d       = rcon_q;
      cur_d        = cur_q;
      keys_valid_d = keys_valid_q;
      kmem_d       = kmem_q;

      if (flush_i) begin
         state_d      = ST_IDLE;
         keys_valid_d = 1'b0;
         rnd_d        = '0;
         rcon_d       = RCON_INIT;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (key_valid_i) begin
                  kmem_d[0]    = key_i;
                  cur_d        = key_i;
                  rnd_d        = IDX_W'(1);
                  rcon_d       = RCON_INIT;
                  keys_valid_d = 1'b0;
                  state_d      = ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               kmem_d[rnd_q] = step_key_i;
               cur_d         = step_key_i;
               rcon_d        = xtime(rcon_q);
               rnd_d         = rnd_q + IDX_W'(1);
               if (rnd_q == NR_L) begin
                  state_d      = ST_DONE;
                  keys_valid_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from registered state; read port is combinational
   assign key_ready_o  = (state_q != ST_EXPAND);
   assign busy_o       = (state_q == ST_EXPAND);
   assign keys_valid_o = keys_valid_q;
   assign step_key_o   = cur_q;
   assign step_rcon_o  = rcon_q;
   assign rk_o         = (rk_idx_i <= NR_L) ? kmem_q[rk_idx_i] : '0;

endmodule
